// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared constants and helpers for the display blocks: default VGA 640x480
// timing, text-window defaults, total-count derivation, a constant clog2 and
// the sync inactive level for a given polarity.
// -----------------------------------------------------------------------------
package disp_pkg;

   // Default 640x480 @ 60 Hz timing (pixel clocks / lines)
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam bit DEF_SYNC_POL = 1'b0;

   // Text window defaults
   localparam int DEF_RGB_W        = 9;
   localparam int DEF_NUM_CHARS    = 8;
   localparam int DEF_CODE_W       = 7;
   localparam int DEF_GLYPH_W      = 8;
   localparam int DEF_GLYPH_H      = 16;
   localparam int DEF_SCALE_LOG2   = 0;
   localparam int DEF_FLASH_FRAMES = 32;

   // Total clocks per line / lines per frame
   function automatic int lineTotal(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   // Smallest r with 2**r >= value (0 for value <= 1)
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   function automatic int maxInt(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Level a sync output rests at outside its pulse
   function automatic logic syncIdle(input logic pol);
      return ~pol;
   endfunction

endpackage

// File: rtl/disp_timing_gen.sv
// -----------------------------------------------------------------------------
// disp_timing_gen
// Free-running VGA raster counters with combinational sync/blank decode and a
// registered start-of-frame pulse.
// Ports:
//   clock, reset      pixel clock, async active-high reset
//   hCnt, vCnt        current pixel / line position
//   hSync, vSync      sync levels decoded from the current position
//   blank             position outside the active area
//   lastOfFrame       final clock of the frame (last pixel of last line)
//   frameStart        one-clock pulse, the clock after position (0,0)
// -----------------------------------------------------------------------------
module disp_timing_gen import disp_pkg::*; #(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit SYNC_POL = DEF_SYNC_POL,
   parameter int H_W      = clog2(lineTotal(H_ACTIVE, H_FP, H_SYNC, H_BP)),
   parameter int V_W      = clog2(lineTotal(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
   input  logic           clock,
   input  logic           reset,
   output logic [H_W-1:0] hCnt,
   output logic [V_W-1:0] vCnt,
   output logic           hSync,
   output logic           vSync,
   output logic           blank,
   output logic           lastOfFrame,
   output logic           frameStart
);

   localparam int H_TOTAL = lineTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = lineTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);

   logic lastOfLine;

   assign lastOfLine  = (hCnt == H_W'(H_TOTAL - 1));
   assign lastOfFrame = lastOfLine && (vCnt == V_W'(V_TOTAL - 1));

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of block order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hCnt       <= '0;
         vCnt       <= '0;
         frameStart <= 1'b0;
      end else begin
         frameStart <= (hCnt == '0) && (vCnt == '0);
         if (lastOfLine) begin
            hCnt <= '0;
            vCnt <= (vCnt == V_W'(V_TOTAL - 1)) ? '0 : vCnt + 1'b1;
         end else begin
            hCnt <= hCnt + 1'b1;
         end
      end
   end

   assign hSync = ((hCnt >= H_W'(H_ACTIVE + H_FP)) && (hCnt <= H_W'(H_ACTIVE + H_FP + H_SYNC - 1)))
                  ? SYNC_POL : syncIdle(SYNC_POL);
   assign vSync = ((vCnt >= V_W'(V_ACTIVE + V_FP)) && (vCnt <= V_W'(V_ACTIVE + V_FP + V_SYNC - 1)))
                  ? SYNC_POL : syncIdle(SYNC_POL);
   assign blank = (hCnt >= H_W'(H_ACTIVE)) || (vCnt >= V_W'(V_ACTIVE));

endmodule

// File: rtl/disp_text_engine.sv
// -----------------------------------------------------------------------------
// disp_text_engine
// Draws a one-line window of NUM_CHARS glyphs from a synchronous font ROM onto
// a VGA raster, with integer scaling, flash and inverse video.
// Ports:
//   clock, reset          pixel clock, async active-high reset
//   enable                0 forces black output (timing keeps running)
//   winX, winY            window top-left, taken at frame boundaries only
//   charCodes             packed codes, char 0 (leftmost) in the LSBs
//   fgRgb, bgRgb          glyph foreground / window background colours
//   flashEn, inverse      flash foreground, swap fg/bg
//   romEn, romAddr        font ROM read request {code, glyphRow}
//   romByte               ROM data, one clock after romEn
//   vgaRGB, vgaHsync,
//   vgaVsync              registered pixel and syncs, 2 clocks after counters
//   frameStart            one-clock pulse per frame
// -----------------------------------------------------------------------------
module disp_text_engine import disp_pkg::*; #(
   parameter int RGB_W        = DEF_RGB_W,
   parameter int H_ACTIVE     = DEF_H_ACTIVE,
   parameter int H_FP         = DEF_H_FP,
   parameter int H_SYNC       = DEF_H_SYNC,
   parameter int H_BP         = DEF_H_BP,
   parameter int V_ACTIVE     = DEF_V_ACTIVE,
   parameter int V_FP         = DEF_V_FP,
   parameter int V_SYNC       = DEF_V_SYNC,
   parameter int V_BP         = DEF_V_BP,
   parameter bit SYNC_POL     = DEF_SYNC_POL,
   parameter int NUM_CHARS    = DEF_NUM_CHARS,
   parameter int CODE_W       = DEF_CODE_W,
   parameter int GLYPH_W      = DEF_GLYPH_W,
   parameter int GLYPH_H      = DEF_GLYPH_H,
   parameter int SCALE_LOG2   = DEF_SCALE_LOG2,
   parameter int FLASH_FRAMES = DEF_FLASH_FRAMES
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              enable,
   input  logic [9:0]                        winX,
   input  logic [9:0]                        winY,
   input  logic [NUM_CHARS*CODE_W-1:0]       charCodes,
   input  logic [RGB_W-1:0]                  fgRgb,
   input  logic [RGB_W-1:0]                  bgRgb,
   input  logic                              flashEn,
   input  logic                              inverse,
   output logic                              romEn,
   output logic [CODE_W+clog2(GLYPH_H)-1:0]  romAddr,
   input  logic [GLYPH_W-1:0]                romByte,
   output logic [RGB_W-1:0]                  vgaRGB,
   output logic                              vgaHsync,
   output logic                              vgaVsync,
   output logic                              frameStart
);

   localparam int ROW_W  = clog2(GLYPH_H);
   localparam int ADDR_W = CODE_W + ROW_W;
   localparam int H_W    = clog2(lineTotal(H_ACTIVE, H_FP, H_SYNC, H_BP));
   localparam int V_W    = clog2(lineTotal(V_ACTIVE, V_FP, V_SYNC, V_BP));
   // One spare bit so window offsets and bounds never overflow
   localparam int DW     = maxInt(maxInt(H_W, V_W), 10) + 1;
   localparam int COL_W  = maxInt(clog2(GLYPH_W), 1);
   localparam int FL_W   = maxInt(clog2(FLASH_FRAMES), 1);
   localparam int WIN_W  = (NUM_CHARS * GLYPH_W) << SCALE_LOG2;
   localparam int WIN_H  = GLYPH_H << SCALE_LOG2;

   // Stage 0: raster position
   logic [H_W-1:0] hCnt;
   logic [V_W-1:0] vCnt;
   logic           hSync0, vSync0, blank0, lastOfFrame;

   disp_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .SYNC_POL(SYNC_POL), .H_W(H_W), .V_W(V_W)
   ) timingGen (
      .clock      (clock),
      .reset      (reset),
      .hCnt       (hCnt),
      .vCnt       (vCnt),
      .hSync      (hSync0),
      .vSync      (vSync0),
      .blank      (blank0),
      .lastOfFrame(lastOfFrame),
      .frameStart (frameStart)
   );

   // Shadowed window origin, ROM address hold, flash state
   logic [9:0]        winXs, winYs;
   logic [ADDR_W-1:0] romAddrHeld;
   logic [FL_W-1:0]   flashCnt;
   logic              flashPhase;

   // Stage 0 window math
   logic [DW-1:0]     hExt, vExt, xOff, yOff, relX, charIdx;
   logic [COL_W-1:0]  col0;
   logic [ROW_W-1:0]  glyphRow;
   logic [CODE_W-1:0] code;
   logic              inside0;

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can leave one unassigned and infer a latch.
      code     = '0;
      hExt     = DW'(hCnt);
      vExt     = DW'(vCnt);
      xOff     = hExt - DW'(winXs);
      yOff     = vExt - DW'(winYs);
      relX     = xOff >> SCALE_LOG2;
      charIdx  = relX / DW'(GLYPH_W);
      col0     = COL_W'(relX % DW'(GLYPH_W));
      glyphRow = ROW_W'(yOff >> SCALE_LOG2);
      for (int i = 0; i < NUM_CHARS; i++) begin
         if (charIdx == DW'(i)) code = charCodes[i*CODE_W +: CODE_W];
      end
      // Blank clips whatever part of the window lies past the active area.
      // Gating with reset keeps the ROM strobe quiet while held in reset.
      inside0 = ~reset && ~blank0
                && (hExt >= DW'(winXs)) && (xOff < DW'(WIN_W))
                && (vExt >= DW'(winYs)) && (yOff < DW'(WIN_H));
   end

   // ROM is read in the same clock as the position so its data meets stage 1
   assign romEn   = inside0;
   assign romAddr = inside0 ? {code, glyphRow} : romAddrHeld;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         winXs       <= '0;
         winYs       <= '0;
         romAddrHeld <= '0;
         flashCnt    <= '0;
         flashPhase  <= 1'b0;
      end else begin
         // Taking the origin only at the frame boundary avoids tearing
         if (lastOfFrame) begin
            winXs <= winX;
            winYs <= winY;
         end
         if (inside0) romAddrHeld <= {code, glyphRow};
         if (frameStart) begin
            if (flashCnt == FL_W'(FLASH_FRAMES - 1)) begin
               flashCnt   <= '0;
               flashPhase <= ~flashPhase;
            end else begin
               flashCnt <= flashCnt + 1'b1;
            end
         end
      end
   end

   // Stage 1 pipeline (aligned with romByte)
   logic             inside1, blank1, hSync1, vSync1;
   logic [COL_W-1:0] col1;

   // Stage 2 pixel decision
   logic [RGB_W-1:0] fgEff, bgEff, pixel;
   logic             glyphBit;

   always_comb begin
      glyphBit = romByte[COL_W'(GLYPH_W - 1) - col1];
      fgEff    = inverse ? bgRgb : fgRgb;
      bgEff    = inverse ? fgRgb : bgRgb;
      if (flashEn && flashPhase) fgEff = bgEff;
      pixel    = (blank1 || ~enable || ~inside1) ? '0 : (glyphBit ? fgEff : bgEff);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         inside1  <= 1'b0;
         blank1   <= 1'b1;
         col1     <= '0;
         hSync1   <= syncIdle(SYNC_POL);
         vSync1   <= syncIdle(SYNC_POL);
         vgaRGB   <= '0;
         vgaHsync <= syncIdle(SYNC_POL);
         vgaVsync <= syncIdle(SYNC_POL);
      end else begin
         inside1  <= inside0;
         blank1   <= blank0;
         col1     <= col0;
         hSync1   <= hSync0;
         vSync1   <= vSync0;
         vgaRGB   <= pixel;
         vgaHsync <= hSync1;
         vgaVsync <= vSync1;
      end
   end

endmodule

// File: tb/tb_disp_text_engine.sv
// -----------------------------------------------------------------------------
// tb_disp_text_engine
// Reduced raster (80x48 clocks, 64x40 active), 3 chars at 2x scale, flash
// half-period of 2 frames. Randomised colours, codes, modes and window origin
// per frame, plus mid-frame origin changes; every output pixel is compared
// against a pixel-by-pixel reference computed from the window rules.
// -----------------------------------------------------------------------------
module tb_disp_text_engine;

   localparam int HA = 64, HFP = 4, HS = 8, HBP = 4, HT = HA + HFP + HS + HBP;
   localparam int VA = 40, VFP = 2, VS = 2, VBP = 4, VT = VA + VFP + VS + VBP;
   localparam int NC = 3, CW = 7, GW = 8, GH = 16, SC = 1, MAG = 2, FF = 2, RW = 9;
   localparam int WIN_W = NC * GW * MAG;
   localparam int WIN_H = GH * MAG;

   typedef struct packed {
      logic [RW-1:0] rgb;
      logic          hs;
      logic          vs;
   } expT;

   logic            clock = 1'b0;
   logic            reset, enable, flashEn, inverse;
   logic [9:0]      winX, winY;
   logic [NC*CW-1:0] charCodes;
   logic [RW-1:0]   fgRgb, bgRgb, vgaRGB;
   logic            romEn, vgaHsync, vgaVsync, frameStart;
   logic [10:0]     romAddr;
   logic [7:0]      romByte = 8'h00;

   logic [7:0]      font [0:2047];
   logic [CW-1:0]   codes [NC];

   int   vectorCount = 0;
   int   missCount   = 0;
   int   bh, bv, frameNo, wxS, wyS, wxNext, wyNext;
   bit   prevOrigin;
   expT  pipe1, pipe2;

   disp_text_engine #(
      .RGB_W(RW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0),
      .NUM_CHARS(NC), .CODE_W(CW), .GLYPH_W(GW), .GLYPH_H(GH),
      .SCALE_LOG2(SC), .FLASH_FRAMES(FF)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .winX      (winX),
      .winY      (winY),
      .charCodes (charCodes),
      .fgRgb     (fgRgb),
      .bgRgb     (bgRgb),
      .flashEn   (flashEn),
      .inverse   (inverse),
      .romEn     (romEn),
      .romAddr   (romAddr),
      .romByte   (romByte),
      .vgaRGB    (vgaRGB),
      .vgaHsync  (vgaHsync),
      .vgaVsync  (vgaVsync),
      .frameStart(frameStart)
   );

   always #5 clock = ~clock;

   // Synchronous font ROM
   always @(posedge clock) if (romEn) romByte <= font[romAddr];

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("FAIL %s at h=%0d v=%0d frame=%0d: got %0h expected %0h",
                  tag, bh, bv, frameNo, observed, expected);
      end
   endtask

   task automatic packCodes();
      for (int i = 0; i < NC; i++) charCodes[i*CW +: CW] = codes[i];
   endtask

   // Expected output for raster position (h,v) of the current frame
   function automatic expT model(input int h, input int v);
      expT           e;
      int            rx, ry, relX, ci, col, row, n, fontIdx;
      logic [7:0]    glyph;
      logic [RW-1:0] fgE, bgE;
      e.hs  = (h >= HA + HFP && h < HA + HFP + HS) ? 1'b0 : 1'b1;
      e.vs  = (v >= VA + VFP && v < VA + VFP + VS) ? 1'b0 : 1'b1;
      e.rgb = '0;
      rx = h - wxS;
      ry = v - wyS;
      if (h < HA && v < VA && enable && rx >= 0 && rx < WIN_W && ry >= 0 && ry < WIN_H) begin
         relX    = rx / MAG;
         ci      = relX / GW;
         col     = relX % GW;
         row     = ry / MAG;
         fontIdx = int'(codes[ci]) * GH + row;
         glyph   = font[11'(fontIdx)];
         fgE = inverse ? bgRgb : fgRgb;
         bgE = inverse ? fgRgb : bgRgb;
         // Frame k has seen k frameStart pulses, except its very first pixel,
         // whose output is formed as that frame's pulse is being counted.
         n = (h == 0 && v == 0) ? frameNo - 1 : frameNo;
         if (flashEn && ((n / FF) % 2 == 1)) fgE = bgE;
         e.rgb = (((int'(glyph) >> (GW - 1 - col)) & 1) == 1) ? fgE : bgE;
      end
      return e;
   endfunction

   task automatic drive();
      // New frame settings while the raster is vertically blanked
      if (bv == VA && bh == 10) begin
         enable  = ($urandom_range(0, 5) != 0);
         flashEn = 1'($urandom_range(0, 1));
         inverse = 1'($urandom_range(0, 1));
         fgRgb   = RW'($urandom);
         bgRgb   = RW'($urandom);
         for (int i = 0; i < NC; i++) codes[i] = CW'($urandom);
         packCodes();
         winX = 10'($urandom_range(0, HA + 12));
         winY = 10'($urandom_range(0, VA + 6));
         if (frameNo == 4) winX = 10'(HA - 4);
         if (frameNo == 6) begin
            winX = 10'd0;
            winY = 10'd0;
         end
      end
      // Mid-frame origin change on odd frames: must only show next frame
      if ((frameNo % 2) == 1 && bv == VA / 2 && bh == 7) begin
         winX = 10'($urandom_range(0, HA + 12));
         winY = 10'($urandom_range(0, VA + 6));
      end
   endtask

   task automatic stepCycle();
      @(negedge clock);
      bh++;
      if (bh == HT) begin
         bh = 0;
         bv++;
         if (bv == VT) bv = 0;
      end
      if (bh == 0 && bv == 0) begin
         frameNo++;
         wxS = wxNext;
         wyS = wyNext;
      end
      check("rgb",        32'(vgaRGB),     32'(pipe2.rgb));
      check("hsync",      32'(vgaHsync),   32'(pipe2.hs));
      check("vsync",      32'(vgaVsync),   32'(pipe2.vs));
      check("frameStart", 32'(frameStart), 32'(prevOrigin));
      pipe2      = pipe1;
      prevOrigin = (bh == 0 && bv == 0);
      drive();
      if (bh == HT - 1 && bv == VT - 1) begin
         wxNext = int'(winX);
         wyNext = int'(winY);
      end
      pipe1 = model(bh, bv);
   endtask

   task automatic checkResetOutputs(input string tagPrefix);
      check({tagPrefix, "Rgb"},        32'(vgaRGB),     32'h0);
      check({tagPrefix, "Hsync"},      32'(vgaHsync),   32'h1);
      check({tagPrefix, "Vsync"},      32'(vgaVsync),   32'h1);
      check({tagPrefix, "RomEn"},      32'(romEn),      32'h0);
      check({tagPrefix, "RomAddr"},    32'(romAddr),    32'h0);
      check({tagPrefix, "FrameStart"}, 32'(frameStart), 32'h0);
   endtask

   // Releases reset at a falling edge; that clock is raster position (0,0)
   task automatic releaseReset();
      @(negedge clock);
      checkResetOutputs("reset");
      reset      = 1'b0;
      bh         = 0;
      bv         = 0;
      frameNo    = 1;
      wxS        = 0;
      wyS        = 0;
      wxNext     = 0;
      wyNext     = 0;
      prevOrigin = 1'b1;
      pipe2      = '{rgb: '0, hs: 1'b1, vs: 1'b1};
      pipe1      = model(0, 0);
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);
      reset   = 1'b1;
      enable  = 1'b1;
      flashEn = 1'b1;
      inverse = 1'b0;
      fgRgb   = 9'h1FF;
      bgRgb   = 9'h007;
      winX    = 10'd0;
      winY    = 10'd0;
      codes[0] = 7'h41;
      codes[1] = 7'h42;
      codes[2] = 7'h43;
      packCodes();

      repeat (3) @(negedge clock);
      releaseReset();
      repeat (8 * HT * VT) stepCycle();

      // Asynchronous reset in the middle of a visible line
      for (int i = 0; i < HT * VT && !(bv == 12 && bh == 30); i++) stepCycle();
      #3;
      reset = 1'b1;
      #1;
      checkResetOutputs("midReset");

      releaseReset();
      repeat (3 * HT) stepCycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/disp_text_engine.md
Name: disp_text_engine

Overview:
Parametrised successor of the single-character display controller. Integrates VGA timing, a window of NUM_CHARS glyphs from a synchronous font ROM, integer glyph scaling, flash and inverse modes, and a registered RGB/sync output stage. Sits between the font ROM and the VGA pins; a host supplies the window position, character codes and colours.

Parameters:
RGB_W, 9, colour output width
H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in clocks
V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines
SYNC_POL, 0, sync active level (0 = active-low)
NUM_CHARS, 8, characters in the window
CODE_W, 7, character code width
GLYPH_W, 8, glyph width in pixels (= romByte width)
GLYPH_H, 16, glyph height in rows (power of 2)
SCALE_LOG2, 0, glyph magnification 2^SCALE_LOG2 (0..2)
FLASH_FRAMES, 32, frames per flash half-period

Ports:
clock  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
enable  in  1  0 = force background-free black output; timing keeps running
winX  in  10  window left pixel
winY  in  10  window top line
charCodes  in  NUM_CHARS*CODE_W  packed codes; char 0 in LSBs, leftmost
fgRgb  in  RGB_W  foreground colour
bgRgb  in  RGB_W  window background colour
flashEn  in  1  enable foreground flashing
inverse  in  1  swap fg/bg
romEn  out  1  ROM read strobe
romAddr  out  CODE_W+log2(GLYPH_H)  {code, glyphRow}
romByte  in  GLYPH_W  ROM data, valid 1 clock after romEn
vgaRGB  out  RGB_W  registered pixel colour
vgaHsync  out  1  registered hsync
vgaVsync  out  1  registered vsync
frameStart  out  1  1-clock pulse, hCnt=0 and vCnt=0

Behaviour:
- Reset (async, active-high): hCnt=vCnt=0, flash counter/phase 0, vgaRGB=0, vgaHsync=vgaVsync=~SYNC_POL, romEn=0, romAddr=0, frameStart=0, shadow winX/winY=0. Release mid-line restarts at pixel (0,0).
- Stage 0: hCnt wraps at H_TOTAL-1 (sum of H params), incrementing vCnt; vCnt wraps at V_TOTAL-1. Sync active for count in [ACTIVE+FP, ACTIVE+FP+SYNC-1]. Blank when hCnt>=H_ACTIVE or vCnt>=V_ACTIVE.
- Window: width NUM_CHARS*GLYPH_W<<SCALE_LOG2, height GLYPH_H<<SCALE_LOG2. winX/winY are sampled into shadow registers only on the last clock of a frame; mid-frame changes take effect next frame (no tearing). Inside = unblanked and within shadow bounds. Any part beyond the active area is clipped, with no wrap.
- Stage 0, inside: romEn=1, relX=(hCnt-winXs)>>SCALE_LOG2, charIdx=relX/GLYPH_W, col=relX%GLYPH_W, glyphRow=(vCnt-winYs)>>SCALE_LOG2, romAddr={code[charIdx], glyphRow}. Outside: romEn=0 and romAddr holds.
- Stage 1: pipelines inside/col/blank/syncs. Stage 2 (output register): bit=romByte[GLYPH_W-1-col] (MSB leftmost). fg'=inverse?bgRgb:fgRgb, bg'=inverse?fgRgb:bgRgb. If flashEn and phase=1, fg'=bg'. vgaRGB = blank or ~enable ? 0 : inside ? (bit?fg':bg') : 0.
- Latency: counter position (h,v) reaches vgaRGB/vgaHsync/vgaVsync exactly 2 clocks later. Syncs are delayed identically, so alignment is exact.
- Flash: a frame counter increments at each frameStart. At FLASH_FRAMES-1 it wraps to 0 and phase toggles. Phase runs regardless of flashEn.
- frameStart is combinational from stage-0 counters, registered once (1-clock delay).

Decomposition:
- Package disp_pkg: timing-default constants, H_TOTAL/V_TOTAL derivation, a clog2 function, and sync inactive-level helper.
- Sub-module disp_timing_gen: counters, sync, blank, frameStart. Reused by future display blocks.
- The top level holds the window math, ROM interface, flash logic and output pipeline.

Test Plan:
- Reset held then released -> vgaRGB=0, syncs=1, romEn=0. Hsync low for 96 clocks every 800. Vsync low for 1600 clocks every 420000.
- ROM model, winX=100, winY=50, code0=0x41, row0=0x81, fg=0x1FF, bg=0x007 -> line 50: vgaRGB at h+2 = 0x1FF for h=100 and h=107, 0x007 for 101..106, 0 at 99 and 164.
- SCALE_LOG2=1, same stimulus -> each glyph bit spans 2 pixels and each row 2 lines. Window spans h 100..227, lines 50..81.
- winX changed 100->200 at line 300 -> current frame unchanged; next frame's window starts at 200.
- FLASH_FRAMES=2, flashEn=1 -> foreground pixels show bg for frames 2-3, fg for frames 4-5. inverse=1 swaps colours; enable=0 gives all-zero output.
- winX=636 -> only pixels 636..639 are drawn; nothing appears at h 0..3 of the next line; asserting reset mid-line makes all outputs return to reset values immediately.
